atom_kbd_matrix: RTL

//  Keyboard-side end of the 8255 PIA keyboard interface. Holds a 10x6 Atom key matrix

---
 rtl/atom_kbd_matrix.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/atom_kbd_matrix.sv
// Atom keyboard matrix: turns PS/2 scancode bytes into a 10x6 key matrix plus
// CTRL/SHIFT/REPT/BREAK lines, and answers PIA row selects with active-low
// column data.
module atom_kbd_matrix #(
    parameter int NUM_ROWS       = 10,
    parameter int NUM_COLS       = 6,
    parameter bit CLEAR_ON_ERROR = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ps2_code,
    input  logic       ps2_valid,
    input  logic [3:0] row_sel,
    output logic [7:0] key_cols,
    output logic       rept_n,
    output logic       break_n
);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK} state_t;

    typedef enum logic [2:0] {
        K_NONE, K_MATRIX, K_LSHIFT, K_RSHIFT, K_LCTRL, K_RCTRL, K_REPT, K_BREAK
    } kind_t;

    typedef struct packed {
        kind_t      kind;
        logic [3:0] row;
        logic [2:0] col;
    } key_t;

    state_t     state, state_nxt;
    logic       do_make, do_release, do_clear, cur_ext;
    key_t       key;
    logic [5:0] matrix [NUM_ROWS];
    logic       lshift, rshift, lctrl, rctrl, rept, brk;

    function automatic key_t mk(input logic [3:0] row, input logic [2:0] col);
        key_t k;
        k.kind = K_MATRIX;
        k.row  = row;
        k.col  = col;
        return k;
    endfunction

    // {ext,code} -> Atom key position or modifier.
    function automatic key_t map_key(input logic ext, input logic [7:0] code);
        key_t k;
        k.kind = K_NONE;
        k.row  = 4'd0;
        k.col  = 3'd0;
        case ({ext, code})
            9'h012:  k.kind = K_LSHIFT;
            9'h059:  k.kind = K_RSHIFT;
            9'h014:  k.kind = K_LCTRL;
            9'h114:  k.kind = K_RCTRL;
            9'h011:  k.kind = K_REPT;
            9'h007:  k.kind = K_BREAK;
            // row 0: 3 - G Q ESC
            9'h026:  k = mk(4'd0, 3'd1);
            9'h04E:  k = mk(4'd0, 3'd2);
            9'h034:  k = mk(4'd0, 3'd3);
            9'h015:  k = mk(4'd0, 3'd4);
            9'h076:  k = mk(4'd0, 3'd5);
            // row 1: 2 , F P Z
            9'h01E:  k = mk(4'd1, 3'd1);
            9'h041:  k = mk(4'd1, 3'd2);
            9'h02B:  k = mk(4'd1, 3'd3);
            9'h04D:  k = mk(4'd1, 3'd4);
            9'h01A:  k = mk(4'd1, 3'd5);
            // row 2: UP 1 ; E O Y
            9'h175:  k = mk(4'd2, 3'd0);
            9'h016:  k = mk(4'd2, 3'd1);
            9'h04C:  k = mk(4'd2, 3'd2);
            9'h024:  k = mk(4'd2, 3'd3);
            9'h044:  k = mk(4'd2, 3'd4);
            9'h035:  k = mk(4'd2, 3'd5);
            // row 3: RIGHT 0 / D A X
            9'h174:  k = mk(4'd3, 3'd0);
            9'h045:  k = mk(4'd3, 3'd1);
            9'h04A:  k = mk(4'd3, 3'd2);
            9'h023:  k = mk(4'd3, 3'd3);
            9'h01C:  k = mk(4'd3, 3'd4);
            9'h022:  k = mk(4'd3, 3'd5);
            // row 4: DELETE 9 . C N W
            9'h066:  k = mk(4'd4, 3'd0);
            9'h046:  k = mk(4'd4, 3'd1);
            9'h049:  k = mk(4'd4, 3'd2);
            9'h021:  k = mk(4'd4, 3'd3);
            9'h031:  k = mk(4'd4, 3'd4);
            9'h01D:  k = mk(4'd4, 3'd5);
            // row 5: COPY(TAB) 8 ' B M V
            9'h00D:  k = mk(4'd5, 3'd0);
            9'h03E:  k = mk(4'd5, 3'd1);
            9'h052:  k = mk(4'd5, 3'd2);
            9'h032:  k = mk(4'd5, 3'd3);
            9'h03A:  k = mk(4'd5, 3'd4);
            9'h02A:  k = mk(4'd5, 3'd5);
            // row 6: 7 RETURN L S K U
            9'h03D:  k = mk(4'd6, 3'd0);
            9'h05A:  k = mk(4'd6, 3'd1);
            9'h04B:  k = mk(4'd6, 3'd2);
            9'h01B:  k = mk(4'd6, 3'd3);
            9'h042:  k = mk(4'd6, 3'd4);
            9'h03C:  k = mk(4'd6, 3'd5);
            // row 7: 6 5 J R I T
            9'h036:  k = mk(4'd7, 3'd0);
            9'h02E:  k = mk(4'd7, 3'd1);
            9'h03B:  k = mk(4'd7, 3'd2);
            9'h02D:  k = mk(4'd7, 3'd3);
            9'h043:  k = mk(4'd7, 3'd4);
            9'h02C:  k = mk(4'd7, 3'd5);
            // row 8: 4 H = LOCK [ backslash
            9'h025:  k = mk(4'd8, 3'd0);
            9'h033:  k = mk(4'd8, 3'd1);
            9'h055:  k = mk(4'd8, 3'd2);
            9'h058:  k = mk(4'd8, 3'd3);
            9'h054:  k = mk(4'd8, 3'd4);
            9'h05D:  k = mk(4'd8, 3'd5);
            // row 9: SPACE ^(backtick) LEFT DOWN ]
            9'h029:  k = mk(4'd9, 3'd0);
            9'h00E:  k = mk(4'd9, 3'd1);
            9'h16B:  k = mk(4'd9, 3'd2);
            9'h172:  k = mk(4'd9, 3'd3);
            9'h05B:  k = mk(4'd9, 3'd4);
            default: k.kind = K_NONE;
        endcase
        return k;
    endfunction

    function automatic logic is_error_code(input logic [7:0] code);
        return (code == 8'h00) || (code == 8'hFF) || (code == 8'hAA);
    endfunction

    assign key = map_key(cur_ext, ps2_code);

    // Prefix FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Prefix decode: next state and the make/release/clear action for this byte.
    always_comb begin
        state_nxt  = state;
        do_make    = 1'b0;
        do_release = 1'b0;
        do_clear   = 1'b0;
        cur_ext    = 1'b0;
        if (ps2_valid) begin
            if (CLEAR_ON_ERROR && is_error_code(ps2_code)) begin
                do_clear  = 1'b1;
                state_nxt = S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (ps2_code == 8'hE0)      state_nxt = S_EXT;
                        else if (ps2_code == 8'hF0) state_nxt = S_BRK;
                        else                        do_make   = 1'b1;
                    end
                    S_EXT: begin
                        cur_ext = 1'b1;
                        if (ps2_code == 8'hF0) state_nxt = S_EXTBRK;
                        else if (ps2_code != 8'hE0) begin
                            do_make   = 1'b1;
                            state_nxt = S_IDLE;
                        end
                    end
                    S_BRK: begin
                        if (ps2_code != 8'hE0 && ps2_code != 8'hF0) begin
                            do_release = 1'b1;
                            state_nxt  = S_IDLE;
                        end
                    end
                    S_EXTBRK: begin
                        cur_ext = 1'b1;
                        if (ps2_code != 8'hE0 && ps2_code != 8'hF0) begin
                            do_release = 1'b1;
                            state_nxt  = S_IDLE;
                        end
                    end
                    default: state_nxt = S_IDLE;
                endcase
            end
        end
    end

    // Key state: set on make, clear on release, wipe on reset or error code.
    always_ff @(posedge clk) begin
        if (reset || do_clear) begin
            for (int r = 0; r < NUM_ROWS; r++) matrix[r] <= 6'h00;
            lshift <= 1'b0;
            rshift <= 1'b0;
            lctrl  <= 1'b0;
            rctrl  <= 1'b0;
            rept   <= 1'b0;
            brk    <= 1'b0;
        end else if (do_make || do_release) begin
            case (key.kind)
                K_MATRIX: begin
                    if (int'(key.row) < NUM_ROWS && int'(key.col) < NUM_COLS)
                        matrix[key.row][key.col] <= do_make;
                end
                K_LSHIFT: lshift <= do_make;
                K_RSHIFT: rshift <= do_make;
                K_LCTRL:  lctrl  <= do_make;
                K_RCTRL:  rctrl  <= do_make;
                K_REPT:   rept   <= do_make;
                K_BREAK:  brk    <= do_make;
                default:  ;
            endcase
        end
    end

    // Registered PIA-facing outputs, all active low.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_cols <= 8'hFF;
            rept_n   <= 1'b1;
            break_n  <= 1'b1;
        end else begin
            key_cols[5:0] <= (int'(row_sel) < NUM_ROWS) ? ~matrix[row_sel] : 6'h3F;
            key_cols[6]   <= ~(lctrl | rctrl);
            key_cols[7]   <= ~(lshift | rshift);
            rept_n        <= ~rept;
            break_n       <= ~brk;
        end
    end

endmodule
